// File: rtl/shifter_seq_pkg.sv
// Shared encodings for the iterative shifter: operation codes, FSM states and op helpers.
// Used by shifter_seq, shift_step and the bench.
package shifter_seq_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SRA  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // 011 and 111 are unnamed codes that also behave as PASS.
  function automatic logic is_pass(input logic [2:0] op);
    return (op == OP_PASS) || (op == 3'b011) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter/rotator: moves a word by amt bits for the given op and
// reports the last bit shifted out (zero for rotates, pass and amt == 0).
module shift_step
  import shifter_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic [2:0]             op,
  input  logic [SHAMT_WIDTH-1:0] amt,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   carry
);

  logic [SHAMT_WIDTH-1:0]  idx_r;
  logic [SHAMT_WIDTH-1:0]  idx_l;
  logic [2*DATA_WIDTH-1:0] rot_w;
  logic                    nz;

  // NOTE: every output gets a default first, so no path leaves a value held and no latch forms.
  always_comb begin
    nz    = (amt != '0);
    // Index of the last bit leaving the word: amt-1 for right shifts, DATA_WIDTH-amt for left.
    idx_r = amt - SHAMT_WIDTH'(1);
    idx_l = SHAMT_WIDTH'(DATA_WIDTH) - amt;
    rot_w = (op == OP_ROL) ? ({din, din} << amt) : ({din, din} >> amt);
    dout  = din;
    carry = 1'b0;
    case (op)
      OP_SRA: begin
        dout  = $signed(din) >>> amt;
        carry = nz & din[idx_r];
      end
      OP_SLL: begin
        dout  = din << amt;
        carry = nz & din[idx_l];
      end
      OP_SRL: begin
        dout  = din >> amt;
        carry = nz & din[idx_r];
      end
      OP_ROL:  dout = rot_w[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_ROR:  dout = rot_w[DATA_WIDTH-1:0];
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// Iterative multi-mode shifter: accepts an operand on a valid/ready handshake, shifts STEP bits
// per clock, holds the result until consumed. Optional status outputs under SHIFTER_STATUS_EN.
module shifter_seq
  import shifter_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int STEP        = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  dataOut
`ifdef SHIFTER_STATUS_EN
  ,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic                   out_carry
`endif
);

  // One extra bit so STEP == DATA_WIDTH does not wrap to zero.
  localparam logic [SHAMT_WIDTH:0] STEP_C = (SHAMT_WIDTH + 1)'(STEP);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d, step_out;
  logic [2:0]              op_q, op_d;
  logic [SHAMT_WIDTH-1:0]  rem_q, rem_d, step_amt;
  logic                    step_carry;
  logic                    last_step;

  assign step_amt  = ({1'b0, rem_q} > STEP_C) ? STEP_C[SHAMT_WIDTH-1:0] : rem_q;
  assign last_step = ({1'b0, rem_q} <= STEP_C);

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_step (
    .op   (op_q),
    .amt  (step_amt),
    .din  (data_q),
    .dout (step_out),
    .carry(step_carry)
  );

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid)
          state_d = (shamt != '0 && !is_pass(op)) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: if (last_step) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operands are captured only in IDLE; later input changes cannot disturb a running operation.
  always_comb begin
    data_d = data_q;
    op_d   = op_q;
    rem_d  = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = data;
          op_d   = op;
          rem_d  = shamt;
        end
      end
      ST_SHIFT: begin
        data_d = step_out;
        rem_d  = rem_q - step_amt;
      end
      default: ;
    endcase
  end

  // NOTE: datapath flops are reset too, since dataOut must read zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      op_q   <= OP_PASS;
      rem_q  <= '0;
    end else begin
      data_q <= data_d;
      op_q   <= op_d;
      rem_q  <= rem_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign dataOut   = data_q;

`ifdef SHIFTER_STATUS_EN
  logic carry_d;

  // Carry follows the final shifting step; cleared on accept so PASS and shamt == 0 report 0.
  always_comb begin
    carry_d = out_carry;
    case (state_q)
      ST_IDLE:  if (in_valid) carry_d = 1'b0;
      ST_SHIFT: carry_d = step_carry;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      out_carry <= 1'b0;
    end else begin
      out_zero  <= (data_d == '0);
      out_neg   <= data_d[DATA_WIDTH-1];
      out_carry <= carry_d;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = step_carry;
`endif

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: two instances (STEP=1 and STEP=4), directed steps with a scoreboard
// of expected results and latencies; status outputs checked when SHIFTER_STATUS_EN is defined.
module tb_shifter_seq;
  import shifter_seq_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          lat;
    logic        carry;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv1 = 1'b0, iv4 = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] data = 32'd0;
  logic        ir1, ov1, ir4, ov4;
  logic [31:0] do1, do4;
`ifdef SHIFTER_STATUS_EN
  logic        z1, n1, c1, z4, n4, c4;
`endif

  always #5 clk = ~clk;

  shifter_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op), .shamt(shamt),
    .data(data), .out_valid(ov1), .out_ready(out_ready), .dataOut(do1)
`ifdef SHIFTER_STATUS_EN
    , .out_zero(z1), .out_neg(n1), .out_carry(c1)
`endif
  );

  shifter_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op(op), .shamt(shamt),
    .data(data), .out_valid(ov4), .out_ready(out_ready), .dataOut(do4)
`ifdef SHIFTER_STATUS_EN
    , .out_zero(z4), .out_neg(n4), .out_carry(c4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-at-a-time reference: returns {last bit shifted out, result}.
  function automatic logic [32:0] ref_model(input logic [2:0] o, input logic [4:0] s,
                                            input logic [31:0] d);
    logic [31:0] w;
    logic        c;
    w = d;
    c = 1'b0;
    for (int i = 0; i < int'(s); i++) begin
      case (o)
        OP_SRA: begin c = w[0];  w = {w[31], w[31:1]}; end
        OP_SLL: begin c = w[31]; w = {w[30:0], 1'b0}; end
        OP_SRL: begin c = w[0];  w = {1'b0, w[31:1]}; end
        OP_ROL: w = {w[30:0], w[31]};
        OP_ROR: w = {w[0], w[31:1]};
        default: ;
      endcase
    end
    return {c, w};
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [4:0] s, input int step);
    if (o == 3'b000 || o == 3'b011 || o == 3'b111 || s == 5'd0) return 1;
    return 1 + (int'(s) + step - 1) / step;
  endfunction

  function automatic logic cur_ir(input bit sel);
    return sel ? ir4 : ir1;
  endfunction
  function automatic logic cur_ov(input bit sel);
    return sel ? ov4 : ov1;
  endfunction
  function automatic logic [31:0] cur_do(input bit sel);
    return sel ? do4 : do1;
  endfunction

  // Pushes the expectation, accepts the operand, scrambles inputs, waits (bounded) for the result.
  task automatic start_and_wait(input bit sel, input string tag, input logic [2:0] o,
                                input logic [4:0] s, input logic [31:0] d,
                                input logic [31:0] exp_d, input int exp_lat, output int n);
    logic [32:0] r;
    r = ref_model(o, s, d);
    sb.push_back('{tag, exp_d, exp_lat, r[32]});
    check({tag, " in_ready"}, 32'(cur_ir(sel)), 32'd1);
    op = o; shamt = s; data = d;
    if (sel) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    op = 3'($urandom); shamt = 5'($urandom); data = $urandom;
    n = 1;
    while (cur_ov(sel) !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic compare_result(input bit sel, input int n);
    exp_t e;
    e = sb.pop_front();
    check({e.tag, " latency"}, 32'(n), 32'(e.lat));
    check({e.tag, " data"}, cur_do(sel), e.data);
`ifdef SHIFTER_STATUS_EN
    check({e.tag, " zero"},  32'(sel ? z4 : z1), 32'(e.data == 32'd0));
    check({e.tag, " neg"},   32'(sel ? n4 : n1), 32'(e.data[31]));
    check({e.tag, " carry"}, 32'(sel ? c4 : c1), 32'(e.carry));
`endif
  endtask

  task automatic release_result(input bit sel, input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " back to idle"}, {30'd0, cur_ir(sel), cur_ov(sel)}, 32'b10);
  endtask

  task automatic run_op(input bit sel, input string tag, input logic [2:0] o,
                        input logic [4:0] s, input logic [31:0] d,
                        input logic [31:0] exp_d, input int exp_lat);
    int n;
    start_and_wait(sel, tag, o, s, d, exp_d, exp_lat, n);
    compare_result(sel, n);
    release_result(sel, tag);
  endtask

  initial begin
    int          n;
    logic        saw;
    logic [32:0] r;
    logic [2:0]  ro;
    logic [4:0]  rs;
    logic [31:0] rd;

    // Reset held for one clock.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset in_ready", 32'(ir1), 32'd1);
    check("reset out_valid", 32'(ov1), 32'd0);
    check("reset dataOut", do1, 32'd0);
    check("reset step4 dataOut", do4, 32'd0);

    run_op(1'b0, "sra1 legacy", OP_SRA, 5'd1, 32'h88888888, 32'hC4444444, 2);
    run_op(1'b0, "sll8 step1", OP_SLL, 5'd8, 32'h88888888, 32'h88888800, 9);
    run_op(1'b1, "sll8 step4", OP_SLL, 5'd8, 32'h88888888, 32'h88888800, 3);
    run_op(1'b0, "ror31 step1", OP_ROR, 5'd31, 32'h00000001, 32'h00000002, 32);
    run_op(1'b1, "ror31 step4", OP_ROR, 5'd31, 32'h00000001, 32'h00000002, 9);
    run_op(1'b0, "pass shamt7", OP_PASS, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    run_op(1'b0, "pass code 111", 3'b111, 5'd3, 32'h0000F00D, 32'h0000F00D, 1);
    run_op(1'b1, "rol shamt0", OP_ROL, 5'd0, 32'h80000001, 32'h80000001, 1);
    run_op(1'b1, "sra31 step4", OP_SRA, 5'd31, 32'h80000000, 32'hFFFFFFFF, 9);
    run_op(1'b0, "srl1 status", OP_SRL, 5'd1, 32'h00000001, 32'h00000000, 2);

    // Backpressure: result held 5 clocks with a competing in_valid that must be ignored.
    start_and_wait(1'b0, "backpressure", OP_SLL, 5'd4, 32'h12345678, 32'h23456780, 5, n);
    compare_result(1'b0, n);
    iv1 = 1'b1;
    data = 32'hA5A5A5A5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("held out_valid", 32'(ov1), 32'd1);
      check("held dataOut", do1, 32'h23456780);
      check("held in_ready", 32'(ir1), 32'd0);
    end
    iv1 = 1'b0;
    release_result(1'b0, "backpressure");
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      saw |= ov1;
    end
    check("ignored in_valid not queued", 32'(saw), 32'd0);

    // Reset lands mid-operation: SRL by 20 is discarded, nothing is emitted.
    op = OP_SRL; shamt = 5'd20; data = 32'hF0000000; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset in_ready", 32'(ir1), 32'd1);
    check("midreset out_valid", 32'(ov1), 32'd0);
    check("midreset dataOut", do1, 32'd0);
    saw = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      saw |= ov1;
    end
    check("midreset no result", 32'(saw), 32'd0);
    run_op(1'b0, "after midreset", OP_SRL, 5'd20, 32'hF0000000, 32'h00000F00, 21);

    // Mixed operations against the bit-serial reference on both instances.
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      rs = 5'($urandom_range(0, 31));
      rd = $urandom;
      r  = ref_model(ro, rs, rd);
      run_op(i[0], $sformatf("mixed%0d op%0d sh%0d", i, ro, rs), ro, rs, rd, r[31:0],
             exp_latency(ro, rs, i[0] ? 4 : 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
